mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the fetch stage (instruction reads) and the memory stage (data loads and stores) of the 5-stage pipeline.
- Arbitrates between the two requesters and sequences each access.
- Returns read data to the winning requester.
- Drives per-stage stall signals consumed by the pipeline-register enables and bubble logic.
- Data accesses win by default; a starvation guard bounds fetch wait.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/memarb_sat_cnt.sv | 24 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state/owner encodings and default sizes for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } arbStateT;

    localparam logic OWN_IF   = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/memarb_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module memarb_sat_cnt
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between fetch and data requesters.
// Optional performance counters are enabled by defining MEMARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEMARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflicts,
    output logic [31:0]       perf_if_wait
`endif
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int WAIT_W   = $clog2(MEM_LAT + 1);

    arbStateT            state;
    arbStateT            nextState;
    logic                owner;
    logic                curWe;
    logic [STARVE_W-1:0] starveCnt;
    logic [WAIT_W-1:0]   waitCnt;
    logic                arbitrate;
    logic                grantData;
    logic                starveInc;
    logic                starveClr;

    // Data wins unless a waiting fetch has already lost STARVE_MAX times in a row.
    always_comb begin
        arbitrate = 1'b0;
        grantData = 1'b0;
        starveInc = 1'b0;
        starveClr = 1'b0;
        nextState = state;
        case (state)
            ST_IDLE: begin
                arbitrate = if_req || data_req;
                grantData = data_req && !(if_req && (starveCnt == STARVE_W'(STARVE_MAX)));
                starveInc = arbitrate && grantData && if_req;
                starveClr = arbitrate && !starveInc;
                if (arbitrate) nextState = ST_ACCESS;
            end
            ST_ACCESS: nextState = curWe ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (waitCnt == '0) nextState = ST_DONE;
            ST_DONE:   nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= nextState;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= OWN_IF;
            curWe     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            waitCnt   <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arbitrate) begin
                        owner    <= grantData ? OWN_DATA : OWN_IF;
                        curWe    <= grantData && data_we;
                        mem_en   <= 1'b1;
                        mem_we   <= grantData && data_we;
                        mem_addr <= grantData ? data_addr : if_addr;
                        if (grantData && data_we) mem_wdata <= data_wdata;
                    end
                end
                ST_ACCESS: waitCnt <= WAIT_W'(MEM_LAT - 1);
                ST_WAIT: begin
                    if (waitCnt == '0) rdata <= mem_rdata;
                    else               waitCnt <= waitCnt - WAIT_W'(1);
                end
                default: ;
            endcase
        end
    end

    memarb_sat_cnt #(.WIDTH(STARVE_W)) uStarveCnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (starveClr),
        .inc     (starveInc),
        .count   (starveCnt)
    );

    assign if_ack    = (state == ST_DONE) && (owner == OWN_IF);
    assign data_ack  = (state == ST_DONE) && (owner == OWN_DATA);
    assign stall_if  = if_req && !if_ack;
    assign stall_mem = data_req && !data_ack;

`ifdef MEMARB_PERF_CNT_EN
    memarb_sat_cnt #(.WIDTH(32)) uConflictCnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (arbitrate && if_req && data_req),
        .count   (perf_conflicts)
    );

    memarb_sat_cnt #(.WIDTH(32)) uIfWaitCnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (stall_if),
        .count   (perf_if_wait)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dutA uses MEM_LAT=1/STARVE_MAX=2, dutB uses MEM_LAT=2/STARVE_MAX=4.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ifReq = 1'b0;
    logic [31:0] ifAddr = '0;
    logic        dataReq = 1'b0;
    logic        dataWe = 1'b0;
    logic [31:0] dataAddr = '0;
    logic [31:0] dataWdata = '0;

    logic        ifAckA, dataAckA, stallIfA, stallMemA, memEnA, memWeA;
    logic [31:0] rdataA, memAddrA, memWdataA, memRdataA;
    logic        ifAckB, dataAckB, stallIfB, stallMemB, memEnB, memWeB;
    logic [31:0] rdataB, memAddrB, memWdataB, memRdataB;
`ifdef MEMARB_PERF_CNT_EN
    logic [31:0] perfConflictsA, perfIfWaitA, perfConflictsB, perfIfWaitB;
`endif

    logic [31:0] rdPipeA;
    logic [31:0] rdPipeB0, rdPipeB1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) dutA (
        .clk(clk), .reset_n(reset_n),
        .if_req(ifReq), .if_addr(ifAddr), .if_ack(ifAckA),
        .data_req(dataReq), .data_we(dataWe), .data_addr(dataAddr),
        .data_wdata(dataWdata), .data_ack(dataAckA), .rdata(rdataA),
        .stall_if(stallIfA), .stall_mem(stallMemA),
        .mem_en(memEnA), .mem_we(memWeA), .mem_addr(memAddrA),
        .mem_wdata(memWdataA), .mem_rdata(memRdataA)
`ifdef MEMARB_PERF_CNT_EN
        , .perf_conflicts(perfConflictsA), .perf_if_wait(perfIfWaitA)
`endif
    );

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dutB (
        .clk(clk), .reset_n(reset_n),
        .if_req(ifReq), .if_addr(ifAddr), .if_ack(ifAckB),
        .data_req(dataReq), .data_we(dataWe), .data_addr(dataAddr),
        .data_wdata(dataWdata), .data_ack(dataAckB), .rdata(rdataB),
        .stall_if(stallIfB), .stall_mem(stallMemB),
        .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB),
        .mem_wdata(memWdataB), .mem_rdata(memRdataB)
`ifdef MEMARB_PERF_CNT_EN
        , .perf_conflicts(perfConflictsB), .perf_if_wait(perfIfWaitB)
`endif
    );

    // Memory contents are a fixed function of address; outside the valid read slot the bus carries junk.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {a[15:0], 16'hA5A5};
    endfunction

    always_ff @(posedge clk) begin
        rdPipeA  <= (memEnA && !memWeA) ? memWord(memAddrA) : 32'h0BAD_0BAD;
        rdPipeB0 <= (memEnB && !memWeB) ? memWord(memAddrB) : 32'h0BAD_0BAD;
        rdPipeB1 <= rdPipeB0;
    end
    assign memRdataA = rdPipeA;
    assign memRdataB = rdPipeB1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic dReq, input logic dWe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        ifReq     = iReq;
        ifAddr    = iAddr;
        dataReq   = dReq;
        dataWe    = dWe;
        dataAddr  = dAddr;
        dataWdata = dWdata;
    endtask

    // Leaves the bench at cycle 0: reset just released, FSMs idle, caller drives the request next.
    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        $display("[TB] starting mem_port_arbiter bench");

        // Test 1: reset asserted with both requests high.
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput("rst_memEnA", memEnA, 0);
            checkOutput("rst_memEnB", memEnB, 0);
            checkOutput("rst_acksA", {ifAckA, dataAckA, memWeA}, 0);
            checkOutput("rst_rdataA", rdataA, 0);
            checkOutput("rst_memAddrA", memAddrA, 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        settle();
        checkOutput("t1_c0_memEn", memEnA, 0);
        checkOutput("t1_c0_stalls", {stallIfA, stallMemA}, 2'b11);
        tick(); settle();
        checkOutput("t1_c1_memEn", memEnA, 1);
        checkOutput("t1_c1_dataWins", memAddrA, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Test 2: fetch read of 0x40.
        doReset();
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        checkOutput("t2_c0_stallIf", stallIfA, 1);
        checkOutput("t2_c0_memEn", memEnA, 0);
        tick(); settle();
        checkOutput("t2_c1_memEn", memEnA, 1);
        checkOutput("t2_c1_memWe", memWeA, 0);
        checkOutput("t2_c1_memAddr", memAddrA, 32'h40);
        checkOutput("t2_c1_stallIf", stallIfA, 1);
        tick(); settle();
        checkOutput("t2_c2_memEn", memEnA, 0);
        checkOutput("t2_c2_ifAck", ifAckA, 0);
        checkOutput("t2_c2_stallIf", stallIfA, 1);
        tick(); settle();
        checkOutput("t2_c3_ifAck", ifAckA, 1);
        checkOutput("t2_c3_dataAck", dataAckA, 0);
        checkOutput("t2_c3_rdata", rdataA, 32'hDEAD_BEEF);
        checkOutput("t2_c3_stallIf", stallIfA, 0);
        ifReq = 1'b0;
        tick(); settle();
        checkOutput("t2_c4_ifAck", ifAckA, 0);
        checkOutput("t2_c4_dutB_ifAck", ifAckB, 1);
        checkOutput("t2_c4_dutB_rdata", rdataB, 32'hDEAD_BEEF);
        tick();

        // Test 3: store; rdata must keep the earlier read value.
        cyc = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h1234);
        settle();
        checkOutput("t3_c0_stallMem", stallMemA, 1);
        tick(); settle();
        checkOutput("t3_c1_memEn", memEnA, 1);
        checkOutput("t3_c1_memWe", memWeA, 1);
        checkOutput("t3_c1_memAddr", memAddrA, 32'h100);
        checkOutput("t3_c1_memWdata", memWdataA, 32'h1234);
        checkOutput("t3_c1_dataAck", dataAckA, 0);
        tick(); settle();
        checkOutput("t3_c2_dataAck", dataAckA, 1);
        checkOutput("t3_c2_memWe", memWeA, 0);
        checkOutput("t3_c2_rdataKept", rdataA, 32'hDEAD_BEEF);
        checkOutput("t3_c2_stallMem", stallMemA, 0);
        dataReq = 1'b0;
        tick(); settle();
        checkOutput("t3_c3_dataAck", dataAckA, 0);

        // Test 4: simultaneous load and fetch on the MEM_LAT=2 instance.
        doReset();
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0);
        tick(); settle();
        checkOutput("t4_c1_memEn", memEnB, 1);
        checkOutput("t4_c1_dataFirst", memAddrB, 32'h200);
        while (cyc < 4) tick();
        settle();
        checkOutput("t4_c4_acks", {ifAckB, dataAckB}, 2'b01);
        checkOutput("t4_c4_rdata", rdataB, 32'h0200_A5A5);
        checkOutput("t4_c4_stalls", {stallIfB, stallMemB}, 2'b10);
        dataReq = 1'b0;
        while (cyc < 6) tick();
        settle();
        checkOutput("t4_c6_memEn", memEnB, 1);
        checkOutput("t4_c6_fetchAddr", memAddrB, 32'h80);
        while (cyc < 9) tick();
        settle();
        checkOutput("t4_c9_acks", {ifAckB, dataAckB}, 2'b10);
        checkOutput("t4_c9_rdata", rdataB, 32'h0080_A5A5);
`ifdef MEMARB_PERF_CNT_EN
        checkOutput("t4_perfConflicts", perfConflictsB, 1);
        checkOutput("t4_perfIfWait", perfIfWaitB, 9);
`endif
        ifReq = 1'b0;

        // Test 5: both requests held on the STARVE_MAX=2 instance; grants go D, D, I, D, D, I.
        doReset();
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int k = 0; k < 6; k++) begin
            logic expData;
            expData = (k % 3) != 2;
            while (cyc < 4 * k + 1) tick();
            settle();
            checkOutput($sformatf("t5_grant%0d_memEn", k), memEnA, 1);
            checkOutput($sformatf("t5_grant%0d_addr", k), memAddrA, expData ? 32'h200 : 32'h40);
            while (cyc < 4 * k + 3) tick();
            settle();
            checkOutput($sformatf("t5_grant%0d_ack", k), {ifAckA, dataAckA}, expData ? 2'b01 : 2'b10);
        end

        // Test 6: reset during WAIT of a fetch read abandons it; a retry completes normally.
        doReset();
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        while (cyc < 2) tick();
        reset_n = 1'b0;
        settle();
        checkOutput("t6_rst_ifAck", ifAckB, 0);
        checkOutput("t6_rst_memEn", memEnB, 0);
        tick(); settle();
        checkOutput("t6_rst2_ifAck", ifAckB, 0);
        tick();
        reset_n = 1'b1;
        cyc = 0;
        settle();
        checkOutput("t6_c0_noStaleAck", ifAckB, 0);
        checkOutput("t6_c0_rdataCleared", rdataB, 0);
        tick(); settle();
        checkOutput("t6_c1_memEn", memEnB, 1);
        checkOutput("t6_c1_memAddr", memAddrB, 32'h40);
        while (cyc < 4) tick();
        settle();
        checkOutput("t6_c4_ifAck", ifAckB, 1);
        checkOutput("t6_c4_rdata", rdataB, 32'hDEAD_BEEF);
        ifReq = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
